// File: rtl/seq_div32.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/ready/done handshake.
// The trial subtraction is a carry-select adder whose upper half uses a +1 (BEC) select.
module seq_div32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] r_o,
    output logic             dz_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam int unsigned LoW  = WIDTH / 2;
    localparam int unsigned HiW  = WIDTH + 1 - LoW;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  p_q, quo_q, d_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  q_res_q, r_res_q;
    logic              dz_q, done_q;

    logic [WIDTH:0]    trial;
    logic [WIDTH:0]    dneg;
    logic [LoW:0]      lo_sum;
    logic [HiW:0]      hi_sum0, hi_sum1, hi_sel;
    logic [WIDTH+1:0]  sum;
    logic              no_borrow;
    logic              unused_sum_msb;
    logic [WIDTH-1:0]  p_d, quo_d;

    assign trial = {p_q, quo_q[WIDTH-1]};
    // One's complement of the zero-extended divisor; carry-in 1 completes the negation.
    assign dneg  = ~{1'b0, d_q};

    always_comb begin
        lo_sum  = {1'b0, trial[LoW-1:0]} + {1'b0, dneg[LoW-1:0]} + {{LoW{1'b0}}, 1'b1};
        hi_sum0 = {1'b0, trial[WIDTH:LoW]} + {1'b0, dneg[WIDTH:LoW]};
        hi_sum1 = hi_sum0 + {{HiW{1'b0}}, 1'b1};
        hi_sel  = lo_sum[LoW] ? hi_sum1 : hi_sum0;
        sum     = {hi_sel, lo_sum[LoW-1:0]};
    end

    // Carry out of the trial add set means trial >= divisor.
    assign no_borrow      = sum[WIDTH+1];
    assign unused_sum_msb = sum[WIDTH];

    always_comb begin
        p_d   = no_borrow ? sum[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], no_borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            p_q     <= '0;
            quo_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            q_res_q <= '0;
            r_res_q <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (y_i == '0) begin
                            q_res_q <= '1;
                            r_res_q <= x_i;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            p_q     <= '0;
                            quo_q   <= x_i;
                            d_q     <= y_i;
                            cnt_q   <= '0;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    p_q   <= p_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        q_res_q <= quo_d;
                        r_res_q <= p_d;
                        dz_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready_o = (state_q == StIdle);
    assign done_o  = done_q;
    assign q_o     = q_res_q;
    assign r_o     = r_res_q;
    assign dz_o    = dz_q;

endmodule
